data_memory: RTL and testbench
==============================

# data_memory

Byte-addressable 4 KiB data memory for the MA (memory-access) stage of the RV32IM pipeline. It performs synchronous byte, half-word and word stores and combinational, zero-extended loads of the same sizes. Misaligned accesses are suppressed. Sign extension for LB/LH is done downstream in the MA stage.

## Interface
Parameters:
- `ADDR_BITS`, default 12: byte-address bits decoded; memory size is 2^ADDR_BITS bytes.

Ports:
- `CLK`  in  1: the single clock; all stores take effect on its rising edge.
- `RESET`  in  1: asynchronous, active-low reset that clears the whole array.
- `WRITE`  in  2: store size. 00 none, 01 byte, 10 half-word, 11 word.
- `READ`  in  2: load size, same encoding as `WRITE`.
- `ADDR`  in  32: byte address. Bits [31:ADDR_BITS] are ignored, so the address wraps.
- `DATA_IN`  in  32: store data. Byte stores use [7:0]; half-word stores use [15:0].
- `DATA_OUT`  out  32: load result, zero-extended.

## Operation
- Storage is 1024 words × 32 bits, little-endian. Byte k of word w is byte address 4w+k and sits in bits [8k+7:8k].
- Word index is ADDR[11:2]; the lane is ADDR[1:0].
- Alignment rule:
  - Word access requires ADDR[1:0]=00.
  - Half-word access requires ADDR[0]=0.
  - Byte access is always aligned.
- Store:
  - Byte: DATA_IN[7:0] goes to lane ADDR[1:0].
  - Half-word: DATA_IN[15:0] goes to lanes {ADDR[1],0} and {ADDR[1],1}.
  - Word: all four lanes are written.
  - Lanes not selected keep their contents.
  - A misaligned store writes nothing.
- Load:
  - Byte: {24'b0, selected byte}.
  - Half-word: {16'b0, selected half}.
  - Word: the full word.
  - A misaligned load returns 0.
  - READ=00 returns 0.
- READ and WRITE may both be non-zero in the same cycle; each acts independently.

## Timing
- Reset:
  - While RESET=0, every location is 0 and DATA_OUT=0, independent of CLK.
  - Stores are ignored during reset.
  - A store coinciding with the assertion of reset is lost.
- Store latency: contents change at the first rising CLK edge at which WRITE≠00 and RESET=1.
- Load latency: zero cycles. DATA_OUT is a combinational function of READ, ADDR and the array, valid within the same cycle.
- Read during write to the same address: DATA_OUT shows the old data until the edge, then the new data after the edge.
- There is no handshake and no stall; every access completes in one cycle.

## Structure
- Shared package `dmem_pkg`:
  - Size-code constants `MEM_NONE`, `MEM_BYTE`, `MEM_HALF`, `MEM_WORD` (2'b00 to 2'b11).
  - `DMEM_WORDS` = 1024.
  - These constants are reused by the MA-stage control and load-extension logic.
- One sub-module, `dmem_lane_align`. It is purely combinational and produces:
  - the 4-bit byte-enable mask and lane-shifted write data from (WRITE, ADDR[1:0], DATA_IN);
  - the extracted, zero-extended load data from (READ, ADDR[1:0], word);
  - a misaligned flag.
- The top level holds the array, reset clearing, and write-enable gating.

## Test plan
- Word round trip: store 11 at 0x000 DEADBEEF, 0x004 CAFEBABE, 0x008 12345678. Word loads return each value. Word loads at 0x001, 0x002 and 0x003 return 00000000.
- Half-word: store 10 at 0x010 with 0000ABCD and at 0x012 with 0000EF12.
  - Half loads return 0000ABCD and 0000EF12.
  - Word load at 0x010 returns EF12ABCD.
  - Half loads at 0x011 and 0x013 return 0.
- Bytes: store AA, BB, CC, DD at 0x020 to 0x023.
  - Each byte load returns 000000xx.
  - Word load at 0x020 returns DDCCBBAA.
  - A misaligned word store at 0x025 leaves 0x024 unchanged.
- Mixed: word store 12345678 at 0x030.
  - Byte loads at 0x030 to 0x033 return 78, 56, 34, 12 (zero-extended).
  - Half loads at 0x030 and 0x032 return 00005678 and 00001234.
- Reset: after the stores above, drive RESET=0 without waiting for a clock edge.
  - DATA_OUT is immediately 0.
  - After release, words at 0x000 and 0x004 read 0.
- Edge and no-op:
  - Word store FFFFFFFF at 0xFFC reads back FFFFFFFF.
  - Address 0x1000 aliases to 0x000.
  - READ=00 gives DATA_OUT=0.
  - A simultaneous load and store at the same address shows the old value before the edge and the new value after it.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared memory-access definitions for the MA stage: size codes, array depth
// and the alignment rule used by both the store and load paths.
package dmem_pkg;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_BYTE = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_WORD = 2'b11;

  localparam int DMEM_WORDS = 1024;

  // True when an access of the given size may start at this byte lane.
  function automatic logic mem_aligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      MEM_WORD: mem_aligned = (lane == 2'b00);
      MEM_HALF: mem_aligned = ~lane[0];
      default:  mem_aligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables / shifted data and
// zero-extended load extraction from a 32-bit little-endian word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  wr_size_i,
  input  logic [1:0]  rd_size_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wr_data_i,
  input  logic [31:0] rd_word_i,
  output logic [3:0]  wr_be_o,
  output logic [31:0] wr_data_o,
  output logic [31:0] rd_data_o,
  output logic        wr_misaligned_o,
  output logic        rd_misaligned_o
);

  logic [31:0] rd_shift;

  assign wr_misaligned_o = (wr_size_i != MEM_NONE) && !mem_aligned(wr_size_i, lane_i);
  assign rd_misaligned_o = (rd_size_i != MEM_NONE) && !mem_aligned(rd_size_i, lane_i);

  // Replicating the store data lets the enable mask alone pick the lanes.
  always_comb begin
    wr_be_o   = 4'b0000;
    wr_data_o = wr_data_i;
    case (wr_size_i)
      MEM_BYTE: begin
        wr_be_o   = 4'b0001 << lane_i;
        wr_data_o = {4{wr_data_i[7:0]}};
      end
      MEM_HALF: begin
        wr_be_o   = wr_misaligned_o ? 4'b0000 : (lane_i[1] ? 4'b1100 : 4'b0011);
        wr_data_o = {2{wr_data_i[15:0]}};
      end
      MEM_WORD: wr_be_o = wr_misaligned_o ? 4'b0000 : 4'b1111;
      default:  wr_be_o = 4'b0000;
    endcase
  end

  assign rd_shift = rd_word_i >> {lane_i, 3'b000};

  always_comb begin
    rd_data_o = 32'h0;
    if (!rd_misaligned_o) begin
      case (rd_size_i)
        MEM_BYTE: rd_data_o = {24'h0, rd_shift[7:0]};
        MEM_HALF: rd_data_o = {16'h0, rd_shift[15:0]};
        MEM_WORD: rd_data_o = rd_word_i;
        default:  rd_data_o = 32'h0;
      endcase
    end
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable data memory for the MA stage: synchronous byte/half/word
// stores, combinational zero-extended loads, async active-low clear.
module data_memory
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  WRITE,
  input  logic [1:0]  READ,
  input  logic [31:0] ADDR,
  input  logic [31:0] DATA_IN,
  output logic [31:0] DATA_OUT
);

  localparam int WORDS = 2 ** (ADDR_BITS - 2);
  localparam int IDX_W = ADDR_BITS - 2;

  logic [31:0]      mem_q [WORDS];
  logic [IDX_W-1:0] word_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;
  logic [31:0]      rd_data;
  logic             wr_misaligned;
  logic             rd_misaligned;
  logic             unused_addr_hi;

  // High address bits are dropped so accesses wrap within the array.
  assign word_idx       = ADDR[ADDR_BITS-1:2];
  assign unused_addr_hi = &{1'b0, ADDR[31:ADDR_BITS], wr_misaligned, rd_misaligned};

  dmem_lane_align u_align (
    .wr_size_i       (WRITE),
    .rd_size_i       (READ),
    .lane_i          (ADDR[1:0]),
    .wr_data_i       (DATA_IN),
    .rd_word_i       (mem_q[word_idx]),
    .wr_be_o         (wr_be),
    .wr_data_o       (wr_data),
    .rd_data_o       (rd_data),
    .wr_misaligned_o (wr_misaligned),
    .rd_misaligned_o (rd_misaligned)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int w = 0; w < WORDS; w++) mem_q[w] <= 32'h0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (wr_be[k]) mem_q[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
    end
  end

  assign DATA_OUT = RESET ? rd_data : 32'h0;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: round trips at every size,
// alignment suppression, async reset, wrap-around and read-during-write.
module tb_data_memory;
  import dmem_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [1:0]  WRITE;
  logic [1:0]  READ;
  logic [31:0] ADDR;
  logic [31:0] DATA_IN;
  logic [31:0] DATA_OUT;

  int n_vec = 0;
  int n_err = 0;

  data_memory #(.ADDR_BITS(12)) dut (
    .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .READ(READ),
    .ADDR(ADDR), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    READ = MEM_NONE; WRITE = sz; ADDR = a; DATA_IN = d;
    @(posedge CLK); #1;
    WRITE = MEM_NONE;
  endtask

  task automatic load(input logic [1:0] sz, input logic [31:0] a);
    READ = sz; ADDR = a; #1;
  endtask

  task automatic test_reset;
    RESET = 1'b0; WRITE = MEM_NONE; READ = MEM_NONE; ADDR = '0; DATA_IN = '0;
    repeat (2) @(negedge CLK);
    // store attempted while reset held must be ignored
    WRITE = MEM_WORD; ADDR = 32'h50; DATA_IN = 32'h13572468;
    READ = MEM_WORD;
    @(posedge CLK); #1;
    n_vec++;
    if (DATA_OUT !== 32'h0) begin n_err++; $display("FAIL reset_out got=%h exp=%h", DATA_OUT, 32'h0); end
    WRITE = MEM_NONE;
    @(negedge CLK); RESET = 1'b1;
    load(MEM_WORD, 32'h50);
    n_vec++;
    if (DATA_OUT !== 32'h0) begin n_err++; $display("FAIL reset_store_ignored got=%h exp=%h", DATA_OUT, 32'h0); end
  endtask

  task automatic test_word;
    logic [31:0] vals [3];
    vals[0] = 32'hDEADBEEF; vals[1] = 32'hCAFEBABE; vals[2] = 32'h12345678;
    for (int i = 0; i < 3; i++) store(MEM_WORD, 32'(4*i), vals[i]);
    for (int i = 0; i < 3; i++) begin
      load(MEM_WORD, 32'(4*i));
      n_vec++;
      if (DATA_OUT !== vals[i]) begin n_err++; $display("FAIL word_rt[%0d] got=%h exp=%h", i, DATA_OUT, vals[i]); end
    end
    for (int i = 1; i < 4; i++) begin
      load(MEM_WORD, 32'(i));
      n_vec++;
      if (DATA_OUT !== 32'h0) begin n_err++; $display("FAIL word_misal[%0d] got=%h exp=%h", i, DATA_OUT, 32'h0); end
    end
  endtask

  task automatic test_half;
    store(MEM_HALF, 32'h10, 32'h0000ABCD);
    store(MEM_HALF, 32'h12, 32'h0000EF12);
    load(MEM_HALF, 32'h10); n_vec++;
    if (DATA_OUT !== 32'h0000ABCD) begin n_err++; $display("FAIL half_lo got=%h exp=%h", DATA_OUT, 32'h0000ABCD); end
    load(MEM_HALF, 32'h12); n_vec++;
    if (DATA_OUT !== 32'h0000EF12) begin n_err++; $display("FAIL half_hi got=%h exp=%h", DATA_OUT, 32'h0000EF12); end
    load(MEM_WORD, 32'h10); n_vec++;
    if (DATA_OUT !== 32'hEF12ABCD) begin n_err++; $display("FAIL half_word got=%h exp=%h", DATA_OUT, 32'hEF12ABCD); end
    load(MEM_HALF, 32'h11); n_vec++;
    if (DATA_OUT !== 32'h0) begin n_err++; $display("FAIL half_misal11 got=%h exp=%h", DATA_OUT, 32'h0); end
    load(MEM_HALF, 32'h13); n_vec++;
    if (DATA_OUT !== 32'h0) begin n_err++; $display("FAIL half_misal13 got=%h exp=%h", DATA_OUT, 32'h0); end
    // misaligned half store must not touch 0x10..0x13
    store(MEM_HALF, 32'h11, 32'h00009999);
    load(MEM_WORD, 32'h10); n_vec++;
    if (DATA_OUT !== 32'hEF12ABCD) begin n_err++; $display("FAIL half_misal_store got=%h exp=%h", DATA_OUT, 32'hEF12ABCD); end
  endtask

  task automatic test_byte;
    logic [7:0] b [4];
    b[0] = 8'hAA; b[1] = 8'hBB; b[2] = 8'hCC; b[3] = 8'hDD;
    for (int i = 0; i < 4; i++) store(MEM_BYTE, 32'h20 + 32'(i), {24'hFFFFFF, b[i]});
    for (int i = 0; i < 4; i++) begin
      load(MEM_BYTE, 32'h20 + 32'(i)); n_vec++;
      if (DATA_OUT !== {24'h0, b[i]}) begin n_err++; $display("FAIL byte_rt[%0d] got=%h exp=%h", i, DATA_OUT, {24'h0, b[i]}); end
    end
    load(MEM_WORD, 32'h20); n_vec++;
    if (DATA_OUT !== 32'hDDCCBBAA) begin n_err++; $display("FAIL byte_word got=%h exp=%h", DATA_OUT, 32'hDDCCBBAA); end
    store(MEM_WORD, 32'h25, 32'h11223344);
    load(MEM_WORD, 32'h24); n_vec++;
    if (DATA_OUT !== 32'h0) begin n_err++; $display("FAIL word_misal_store got=%h exp=%h", DATA_OUT, 32'h0); end
  endtask

  task automatic test_mixed;
    logic [31:0] bexp [4];
    bexp[0] = 32'h78; bexp[1] = 32'h56; bexp[2] = 32'h34; bexp[3] = 32'h12;
    store(MEM_WORD, 32'h30, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      load(MEM_BYTE, 32'h30 + 32'(i)); n_vec++;
      if (DATA_OUT !== bexp[i]) begin n_err++; $display("FAIL mixed_byte[%0d] got=%h exp=%h", i, DATA_OUT, bexp[i]); end
    end
    load(MEM_HALF, 32'h30); n_vec++;
    if (DATA_OUT !== 32'h00005678) begin n_err++; $display("FAIL mixed_half0 got=%h exp=%h", DATA_OUT, 32'h00005678); end
    load(MEM_HALF, 32'h32); n_vec++;
    if (DATA_OUT !== 32'h00001234) begin n_err++; $display("FAIL mixed_half2 got=%h exp=%h", DATA_OUT, 32'h00001234); end
  endtask

  task automatic test_async_reset;
    load(MEM_WORD, 32'h0);
    @(posedge CLK); #3;
    RESET = 1'b0; #1;
    n_vec++;
    if (DATA_OUT !== 32'h0) begin n_err++; $display("FAIL async_reset_out got=%h exp=%h", DATA_OUT, 32'h0); end
    @(negedge CLK); RESET = 1'b1;
    load(MEM_WORD, 32'h0); n_vec++;
    if (DATA_OUT !== 32'h0) begin n_err++; $display("FAIL reset_clr0 got=%h exp=%h", DATA_OUT, 32'h0); end
    load(MEM_WORD, 32'h4); n_vec++;
    if (DATA_OUT !== 32'h0) begin n_err++; $display("FAIL reset_clr4 got=%h exp=%h", DATA_OUT, 32'h0); end
    load(MEM_WORD, 32'h30); n_vec++;
    if (DATA_OUT !== 32'h0) begin n_err++; $display("FAIL reset_clr30 got=%h exp=%h", DATA_OUT, 32'h0); end
  endtask

  task automatic test_edge;
    store(MEM_WORD, 32'hFFC, 32'hFFFFFFFF);
    load(MEM_WORD, 32'hFFC); n_vec++;
    if (DATA_OUT !== 32'hFFFFFFFF) begin n_err++; $display("FAIL top_word got=%h exp=%h", DATA_OUT, 32'hFFFFFFFF); end
    store(MEM_WORD, 32'h1000, 32'h0A0B0C0D);
    load(MEM_WORD, 32'h0); n_vec++;
    if (DATA_OUT !== 32'h0A0B0C0D) begin n_err++; $display("FAIL alias got=%h exp=%h", DATA_OUT, 32'h0A0B0C0D); end
    load(MEM_NONE, 32'h0); n_vec++;
    if (DATA_OUT !== 32'h0) begin n_err++; $display("FAIL read_none got=%h exp=%h", DATA_OUT, 32'h0); end
  endtask

  task automatic test_back_to_back;
    store(MEM_WORD, 32'h40, 32'h11111111);
    @(negedge CLK);
    WRITE = MEM_WORD; READ = MEM_WORD; ADDR = 32'h40; DATA_IN = 32'h55AA55AA; #1;
    n_vec++;
    if (DATA_OUT !== 32'h11111111) begin n_err++; $display("FAIL rdw_old got=%h exp=%h", DATA_OUT, 32'h11111111); end
    @(posedge CLK); #1;
    n_vec++;
    if (DATA_OUT !== 32'h55AA55AA) begin n_err++; $display("FAIL rdw_new got=%h exp=%h", DATA_OUT, 32'h55AA55AA); end
    // byte store with a concurrent half load of the neighbouring lanes
    @(negedge CLK);
    WRITE = MEM_BYTE; READ = MEM_HALF; ADDR = 32'h41; DATA_IN = 32'h000000E7; #1;
    @(posedge CLK); #1;
    WRITE = MEM_NONE;
    load(MEM_WORD, 32'h40); n_vec++;
    if (DATA_OUT !== 32'h55AAE7AA) begin n_err++; $display("FAIL byte_merge got=%h exp=%h", DATA_OUT, 32'h55AAE7AA); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_half();
    test_byte();
    test_mixed();
    test_async_reset();
    test_edge();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
